// File: rtl/funct_generator_ctrl_if.sv
// Control/data bundle between the user-side controls and the function-generator
// controller. The controller takes the slave view; the stimulus side takes master.
interface funct_generator_ctrl_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 8
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic              en_low_i;
    logic              enh_conf_i;
    logic              oneshot_i;
    logic [ADDR_W-1:0] len_i;
    logic              cfg_wr_i;
    logic              cfg_we_o;
    logic [ADDR_W-1:0] cfg_addr_o;
    logic              clrh_addr_o;
    logic              enh_config_o;
    logic              enh_gen_o;
    logic              rd_valid_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [CH_W-1:0]   rd_ch_o;
    logic              done_o;

    modport master (
        output en_low_i, enh_conf_i, oneshot_i, len_i, cfg_wr_i,
        input  cfg_we_o, cfg_addr_o, clrh_addr_o, enh_config_o, enh_gen_o,
               rd_valid_o, rd_addr_o, rd_ch_o, done_o
    );

    modport slave (
        input  en_low_i, enh_conf_i, oneshot_i, len_i, cfg_wr_i,
        output cfg_we_o, cfg_addr_o, clrh_addr_o, enh_config_o, enh_gen_o,
               rd_valid_o, rd_addr_o, rd_ch_o, done_o
    );
endinterface

// File: rtl/funct_generator_ctrl.sv
// Function-generator sequencer: sample-write configuration phase and NCH-way
// interleaved sample read-out, continuous or one-shot. All outputs registered.
module funct_generator_ctrl #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 8,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    funct_generator_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONFI = 2'd1,
        S_GEN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              mode_q, mode_d;
    logic              cfg_we_q, cfg_we_d;
    logic [ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
    logic              clrh_q, clrh_d;
    logic              config_q, config_d;
    logic              gen_q, gen_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CH_W-1:0]   rd_ch_q, rd_ch_d;
    logic              done_q, done_d;
    logic              final_rd;

    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = S_IDLE;
        final_rd = (state_q == S_GEN) && (rd_addr_q == len_q) && (rd_ch_q == LAST_CH);

        case (state_q)
            S_DONE: begin
                if (bus.enh_conf_i)     state_d = S_CONFI;
                else if (!bus.en_low_i) state_d = S_DONE;
                else                    state_d = S_IDLE;
            end
            S_GEN: begin
                if (bus.enh_conf_i)          state_d = S_CONFI;
                else if (mode_q && final_rd) state_d = S_DONE;
                else if (!bus.en_low_i)      state_d = S_GEN;
                else                         state_d = S_IDLE;
            end
            default: begin
                if (bus.enh_conf_i)     state_d = S_CONFI;
                else if (!bus.en_low_i) state_d = S_GEN;
                else                    state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs are derived from the next state so they appear at the entry edge.
    always_comb begin
        wptr_d     = wptr_q;
        len_d      = len_q;
        mode_d     = mode_q;
        cfg_we_d   = 1'b0;
        cfg_addr_d = '0;
        rd_valid_d = 1'b0;
        rd_addr_d  = '0;
        rd_ch_d    = '0;
        clrh_d     = (state_d == S_IDLE) || (state_d == S_CONFI);
        config_d   = (state_d == S_CONFI);
        gen_d      = (state_d == S_GEN);
        done_d     = (state_d == S_DONE) && (state_q != S_DONE);

        if (state_d == S_CONFI) begin
            if (state_q != S_CONFI) begin
                wptr_d = '0;
            end else if (bus.cfg_wr_i) begin
                cfg_we_d   = 1'b1;
                cfg_addr_d = wptr_q;
                wptr_d     = wptr_q + ADDR_W'(1);
            end else begin
                cfg_addr_d = wptr_q;
            end
        end

        if (state_d == S_GEN) begin
            rd_valid_d = 1'b1;
            if (state_q != S_GEN) begin
                len_d  = bus.len_i;
                mode_d = bus.oneshot_i;
            end else if (rd_ch_q == LAST_CH) begin
                rd_addr_d = (rd_addr_q == len_q) ? '0 : rd_addr_q + ADDR_W'(1);
            end else begin
                rd_addr_d = rd_addr_q;
                rd_ch_d   = rd_ch_q + CH_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            len_q      <= '0;
            mode_q     <= 1'b0;
            cfg_we_q   <= 1'b0;
            cfg_addr_q <= '0;
            clrh_q     <= 1'b1;
            config_q   <= 1'b0;
            gen_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_ch_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
            cfg_we_q   <= cfg_we_d;
            cfg_addr_q <= cfg_addr_d;
            clrh_q     <= clrh_d;
            config_q   <= config_d;
            gen_q      <= gen_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            rd_ch_q    <= rd_ch_d;
            done_q     <= done_d;
        end
    end

    assign bus.cfg_we_o     = cfg_we_q;
    assign bus.cfg_addr_o   = cfg_addr_q;
    assign bus.clrh_addr_o  = clrh_q;
    assign bus.enh_config_o = config_q;
    assign bus.enh_gen_o    = gen_q;
    assign bus.rd_valid_o   = rd_valid_q;
    assign bus.rd_addr_o    = rd_addr_q;
    assign bus.rd_ch_o      = rd_ch_q;
    assign bus.done_o       = done_q;
endmodule

// File: tb/tb_funct_generator_ctrl.sv
// Directed bench: instance A (NCH=2, ADDR_W=3) covers reset, write wrap,
// continuous interleave and abort; instance B (NCH=3, ADDR_W=8) covers one-shot.
module tb_funct_generator_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   we_count;

    always #5 clk = ~clk;

    funct_generator_ctrl_if #(.NCH(2), .ADDR_W(3)) a_if ();
    funct_generator_ctrl_if #(.NCH(3), .ADDR_W(8)) b_if ();

    funct_generator_ctrl #(.NCH(2), .ADDR_W(3)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    funct_generator_ctrl #(.NCH(3), .ADDR_W(8)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_if.en_low_i = 1'b1; a_if.enh_conf_i = 1'b0; a_if.oneshot_i = 1'b0;
        a_if.len_i = '0;      a_if.cfg_wr_i = 1'b0;
        b_if.en_low_i = 1'b1; b_if.enh_conf_i = 1'b0; b_if.oneshot_i = 1'b0;
        b_if.len_i = '0;      b_if.cfg_wr_i = 1'b0;

        // Reset state
        tick();
        check("rst_clrh", a_if.clrh_addr_o, 1);
        check("rst_gen", a_if.enh_gen_o, 0);
        check("rst_cfg", a_if.enh_config_o, 0);
        check("rst_valid", a_if.rd_valid_o, 0);
        check("rst_we", a_if.cfg_we_o, 0);
        check("rst_done", b_if.done_o, 0);
        rst = 1'b0;

        // Strobes in IDLE are ignored
        a_if.cfg_wr_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("idle_we", a_if.cfg_we_o, 0);
            check("idle_clrh", a_if.clrh_addr_o, 1);
        end

        // Config entry then 10 writes wrapping at 8
        a_if.cfg_wr_i = 1'b0; a_if.enh_conf_i = 1'b1;
        tick();
        check("conf_entry", a_if.enh_config_o, 1);
        check("conf_addr0", a_if.cfg_addr_o, 0);
        a_if.cfg_wr_i = 1'b1;
        we_count = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_if.cfg_we_o === 1'b1) we_count++;
            check("wr_addr", a_if.cfg_addr_o, i % 8);
        end
        a_if.cfg_wr_i = 1'b0;
        tick();
        if (a_if.cfg_we_o === 1'b1) we_count++;
        check("wr_count", we_count, 10);

        // Continuous interleave, NCH=2, L=2
        a_if.enh_conf_i = 1'b0; a_if.en_low_i = 1'b0; a_if.len_i = 3'd2; a_if.oneshot_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("cont_valid", a_if.rd_valid_o, 1);
            check("cont_addr", a_if.rd_addr_o, (i / 2) % 3);
            check("cont_ch", a_if.rd_ch_o, i % 2);
        end
        check("cont_gen", a_if.enh_gen_o, 1);
        check("cont_clrh", a_if.clrh_addr_o, 0);

        // Reset mid-GEN held for 3 cycles
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mrst_gen", a_if.enh_gen_o, 0);
            check("mrst_valid", a_if.rd_valid_o, 0);
            check("mrst_addr", a_if.rd_addr_o, 0);
            check("mrst_clrh", a_if.clrh_addr_o, 1);
        end
        rst = 1'b0; a_if.en_low_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("post_rst_gen", a_if.enh_gen_o, 0);
            check("post_rst_clrh", a_if.clrh_addr_o, 1);
        end

        // Move pointer to 3, run to addr 5, abort with config request
        a_if.enh_conf_i = 1'b1;
        tick();
        a_if.cfg_wr_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("pre_abort_ptr", a_if.cfg_addr_o, 2);
        a_if.cfg_wr_i = 1'b0; a_if.enh_conf_i = 1'b0; a_if.en_low_i = 1'b0; a_if.len_i = 3'd7;
        for (int i = 0; i < 11; i++) begin
            tick();
            check("run_addr", a_if.rd_addr_o, i / 2);
        end
        a_if.enh_conf_i = 1'b1;
        tick();
        check("abort_gen", a_if.enh_gen_o, 0);
        check("abort_valid", a_if.rd_valid_o, 0);
        check("abort_cfg", a_if.enh_config_o, 1);
        check("abort_clrh", a_if.clrh_addr_o, 1);
        check("abort_ptr", a_if.cfg_addr_o, 0);
        a_if.cfg_wr_i = 1'b1;
        tick();
        check("abort_wr_we", a_if.cfg_we_o, 1);
        check("abort_wr_addr", a_if.cfg_addr_o, 0);
        a_if.cfg_wr_i = 1'b0; a_if.enh_conf_i = 1'b0; a_if.en_low_i = 1'b1;

        // One-shot NCH=3, L=1: six reads then a done pulse
        b_if.en_low_i = 1'b0; b_if.oneshot_i = 1'b1; b_if.len_i = 8'd1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("os_valid", b_if.rd_valid_o, 1);
            check("os_addr", b_if.rd_addr_o, i / 3);
            check("os_ch", b_if.rd_ch_o, i % 3);
            check("os_done_low", b_if.done_o, 0);
        end
        tick();
        check("os_done", b_if.done_o, 1);
        check("os_done_valid", b_if.rd_valid_o, 0);
        check("os_done_gen", b_if.enh_gen_o, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("os_hold_done", b_if.done_o, 0);
            check("os_hold_gen", b_if.enh_gen_o, 0);
            check("os_hold_clrh", b_if.clrh_addr_o, 0);
        end
        b_if.en_low_i = 1'b1;
        tick();
        check("os_idle_clrh", b_if.clrh_addr_o, 1);

        // Config request on the final one-shot read suppresses done
        b_if.en_low_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("fin_addr", b_if.rd_addr_o, 1);
        check("fin_ch", b_if.rd_ch_o, 2);
        b_if.enh_conf_i = 1'b1;
        tick();
        check("fin_done", b_if.done_o, 0);
        check("fin_cfg", b_if.enh_config_o, 1);
        b_if.enh_conf_i = 1'b0; b_if.en_low_i = 1'b1;
        tick();
        check("fin_done2", b_if.done_o, 0);

        // Re-entry: one-shot L=3 to DONE, then continuous L=1
        b_if.en_low_i = 1'b0; b_if.len_i = 8'd3;
        for (int i = 0; i < 12; i++) tick();
        check("re_last_addr", b_if.rd_addr_o, 3);
        tick();
        check("re_done", b_if.done_o, 1);
        b_if.en_low_i = 1'b1;
        tick();
        b_if.en_low_i = 1'b0; b_if.len_i = 8'd1; b_if.oneshot_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("re_valid", b_if.rd_valid_o, 1);
            check("re_addr", b_if.rd_addr_o, (i / 3) % 2);
            check("re_ch", b_if.rd_ch_o, i % 3);
            check("re_done_low", b_if.done_o, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
